// File: rtl/adc_frame_packer.sv
// ---------------------------------------------------------------------------
// adc_frame_packer
//
// Drains the ADC output sample FIFO and emits framed packets on a valid/ready
// stream toward the host readout path. A frame is:
//   header  : {8'hA5, 8'h00, seq[15:0]}
//   samples : 1..FRAME_LEN raw 32-bit FIFO words, in FIFO order
//   trailer : {8'h5A, cnt[7:0], csum[15:0]}   (m_last high with this word)
// csum is the 16-bit wrapping sum of both halves of every sample in the frame.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active low
//   enable       allows a new frame to start (only looked at in IDLE)
//   flush        one-cycle pulse; closes the frame once the FIFO runs dry
//   fifo_empty   ADC output FIFO empty flag
//   fifo_rd_en   ADC output FIFO read strobe (one-cycle pulse)
//   fifo_rd_data ADC output FIFO read data
//   m_data       stream data
//   m_valid      stream valid
//   m_ready      stream ready
//   m_last       marks the trailer word
//   busy         high whenever a frame is in progress
//   seq          sequence number of the next frame to start
//
// Every output is a flop. The FSM is split into a state/output register
// process and a combinational process that computes the next value of every
// register.
// ---------------------------------------------------------------------------
module adc_frame_packer #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned SEQ_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [31:0]          fifo_rd_data,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic [SEQ_WIDTH-1:0] seq
);

  // The trailer count field is 8 bits and the header carries exactly 16 bits
  // of sequence number, so other settings cannot be represented on the wire.
  if (FRAME_LEN < 1 || FRAME_LEN > 255) begin : g_bad_frame_len
    $error("adc_frame_packer: FRAME_LEN must be within 1..255");
  end
  if (SEQ_WIDTH != 16) begin : g_bad_seq_width
    $error("adc_frame_packer: SEQ_WIDTH must be 16");
  end

  localparam logic [7:0] FRAME_LEN_C = 8'(FRAME_LEN);
  localparam logic [7:0] HDR_TAG     = 8'hA5;
  localparam logic [7:0] TRL_TAG     = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_TRAILER
  } state_t;

  // Registered state
  state_t                 state_q;
  logic [7:0]             cnt_q;
  logic [15:0]            csum_q;
  logic                   flush_pend_q;

  // Next-state values
  state_t                 state_d;
  logic [7:0]             cnt_d;
  logic [15:0]            csum_d;
  logic                   flush_pend_d;
  logic                   fifo_rd_en_d;
  logic [31:0]            m_data_d;
  logic                   m_valid_d;
  logic                   m_last_d;
  logic                   busy_d;
  logic [SEQ_WIDTH-1:0]   seq_d;

  // The frame may close either because it is full, or because a flush is
  // pending and nothing is left in the FIFO to drain.
  logic                   frame_full;
  logic                   frame_close;

  assign frame_full  = (cnt_q == FRAME_LEN_C);
  assign frame_close = frame_full || (flush_pend_q && fifo_empty);

  // -------------------------------------------------------------------------
  // Next-state / next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    csum_d       = csum_q;
    fifo_rd_en_d = 1'b0;
    m_data_d     = m_data;
    m_valid_d    = m_valid;
    m_last_d     = m_last;
    seq_d        = seq;
    // A flush seen in any busy state is remembered until the trailer goes out;
    // one seen while idle has no frame to act on and is dropped.
    flush_pend_d = flush_pend_q || (flush && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          m_data_d  = {HDR_TAG, 8'h00, seq[15:0]};
          m_valid_d = 1'b1;
          state_d   = S_HEADER;
        end
      end

      S_HEADER: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = 8'd0;
          csum_d    = 16'd0;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (frame_close) begin
          m_data_d  = {TRL_TAG, cnt_q, csum_q};
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          state_d   = S_TRAILER;
        end else if (!fifo_empty) begin
          // Only one read is ever in flight: the next strobe cannot be issued
          // until this sample has been handed downstream.
          fifo_rd_en_d = 1'b1;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        // The read strobe issued from REQ is high during this cycle, and the
        // word it selects is presented on fifo_rd_data here.
        m_data_d  = fifo_rd_data;
        m_valid_d = 1'b1;
        state_d   = S_SEND;
      end

      S_SEND: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = cnt_q + 8'd1;
          csum_d    = csum_q + m_data[31:16] + m_data[15:0];
          state_d   = S_REQ;
        end
      end

      S_TRAILER: begin
        if (m_ready) begin
          m_valid_d    = 1'b0;
          m_last_d     = 1'b0;
          seq_d        = seq + SEQ_WIDTH'(1);
          // Clearing wins over a flush landing in this same cycle, so a stale
          // request never leaks into the next frame.
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      csum_q       <= 16'd0;
      flush_pend_q <= 1'b0;
      fifo_rd_en   <= 1'b0;
      m_data       <= 32'd0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      busy         <= 1'b0;
      seq          <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      csum_q       <= csum_d;
      flush_pend_q <= flush_pend_d;
      fifo_rd_en   <= fifo_rd_en_d;
      m_data       <= m_data_d;
      m_valid      <= m_valid_d;
      m_last       <= m_last_d;
      busy         <= busy_d;
      seq          <= seq_d;
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_adc_frame_packer
//
// Drives adc_frame_packer from a queue-based ADC FIFO model and collects every
// accepted stream word. Expected frames are built from the list of words
// pushed into the FIFO: header with the expected sequence number, the words
// in order, then a trailer whose count and checksum are computed with plain
// arithmetic over that list.
//
// The FIFO model presents its head word on fifo_rd_data and pops it at the
// clock edge that samples fifo_rd_en high.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adc_frame_packer;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        busy;
  logic [15:0] seq;

  adc_frame_packer #(
    .FRAME_LEN (64),
    .SEQ_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .seq          (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench state
  int          total = 0;
  int          bad   = 0;
  logic [31:0] fifo_q[$];
  logic [31:0] rx_q[$];
  bit          rx_last[$];
  bit          force_empty = 1'b0;
  int          ready_mode  = 0;   // 0: always ready, 1: 1 on / 2 off, 2: random
  int          ph          = 0;
  int          rd_count    = 0;
  int          rd_viol     = 0;
  int          stall_err   = 0;
  logic [15:0] exp_seq     = 16'd0;

  task automatic fifo_sync();
    fifo_empty   = (fifo_q.size() == 0) || force_empty;
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_sync();
  endtask

  // One clock cycle: observe pre-edge values, step the edge, update models,
  // then drive the next cycle's inputs 1 ns after the edge.
  task automatic tick();
    logic        rd, hs, st, pv, pl;
    logic [31:0] pd;
    rd = fifo_rd_en;
    hs = m_valid && m_ready;
    st = m_valid && !m_ready && rst;
    pd = m_data;
    pv = m_valid;
    pl = m_last;
    if (fifo_rd_en && fifo_empty) rd_viol++;
    @(posedge clk);
    #1;
    if (rd) begin
      rd_count++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (hs) begin
      rx_q.push_back(pd);
      rx_last.push_back(pl);
    end
    if (st && (m_data !== pd || m_valid !== pv || m_last !== pl)) stall_err++;
    flush = 1'b0;
    ph++;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = (ph % 3 == 0);
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    fifo_sync();
  endtask

  task automatic start_frame();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (!busy) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_pops(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rd_count >= n) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = (rd_count >= n);
  endtask

  // Reference model: the complete word sequence of one frame.
  function automatic void build_frame(input logic [15:0] s, input logic [31:0] smp[$],
                                      output logic [31:0] fr[$]);
    logic [15:0] cs;
    cs = 16'd0;
    fr = {};
    fr.push_back({8'hA5, 8'h00, s});
    foreach (smp[i]) begin
      fr.push_back(smp[i]);
      cs = cs + smp[i][31:16] + smp[i][15:0];
    end
    fr.push_back({8'h5A, 8'(smp.size()), cs});
  endfunction

  task automatic clear_rx();
    rx_q.delete();
    rx_last.delete();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl: valid=%b last=%b rd_en=%b want 0 0 0", m_valid, m_last, fifo_rd_en);
    end
    total++;
    if (m_data !== 32'h0 || busy !== 1'b0 || seq !== 16'h0) begin
      bad++;
      $display("FAIL reset_val: data=%h busy=%b seq=%h want 0 0 0", m_data, busy, seq);
    end
    rst = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_full_frame();
    logic [31:0] smp[$], fr[$];
    int busy_cycles;
    ready_mode = 0;
    clear_rx();
    rd_count = 0;
    for (int i = 0; i < 64; i++) begin
      smp.push_back(32'h0001_0002);
      push_word(32'h0001_0002);
    end
    start_frame();
    total++;
    if (m_valid !== 1'b1 || m_data !== 32'hA500_0000) begin
      bad++;
      $display("FAIL full_start: valid=%b data=%h want 1 a5000000", m_valid, m_data);
    end
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 400 && busy; i++) begin
      tick();
      if (busy) busy_cycles++;
    end
    total++;
    if (busy_cycles != 195) begin
      bad++;
      $display("FAIL full_cycles: got %0d want 195", busy_cycles);
    end
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL full_len: got %0d words want %0d", rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL full_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
    total++;
    if (rx_q.size() != 0 && rx_q[rx_q.size()-1] !== 32'h5A40_00C0) begin
      bad++;
      $display("FAIL full_trailer: got %h want 5a4000c0", rx_q[rx_q.size()-1]);
    end
    total++;
    if (seq !== 16'd1 || rd_count != 64) begin
      bad++;
      $display("FAIL full_seq: seq=%h reads=%0d want 0001 64", seq, rd_count);
    end
  endtask

  task automatic test_flush();
    logic [31:0] smp[$], fr[$];
    bit ok;
    ready_mode = 0;
    clear_rx();
    rd_count = 0;
    smp = '{32'h0000_FFFF, 32'h0000_0001, 32'h1234_0000};
    foreach (smp[i]) push_word(smp[i]);
    start_frame();
    wait_pops(2, 100, ok);
    flush = 1'b1;
    tick();
    wait_idle(200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL flush_timeout: busy=%b want 0", busy);
    end
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL flush_len: got %0d words want %0d", rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL flush_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
    total++;
    if (rx_q.size() != 0 && rx_q[rx_q.size()-1] !== 32'h5A03_1234) begin
      bad++;
      $display("FAIL flush_trailer: got %h want 5a031234", rx_q[rx_q.size()-1]);
    end
  endtask

  task automatic test_flush_idle();
    logic [31:0] smp[$], fr[$];
    bit ok;
    ready_mode = 0;
    clear_rx();
    flush = 1'b1;   // ignored: nothing in progress
    tick();
    smp = '{32'hDEAD_BEEF, 32'h0F0F_F0F0};
    foreach (smp[i]) push_word(smp[i]);
    start_frame();
    for (int i = 0; i < 30; i++) tick();
    total++;
    if (busy !== 1'b1 || rx_q.size() != 3) begin
      bad++;
      $display("FAIL idle_flush_ignored: busy=%b words=%0d want 1 3", busy, rx_q.size());
    end
    flush = 1'b1;
    tick();
    wait_idle(100, ok);
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (!ok || rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL idle_flush_len: idle=%b got %0d words want %0d", ok, rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL idle_flush_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
  endtask

  task automatic test_flush_at_full();
    logic [31:0] smp[$], fr[$], w;
    bit ok, fired;
    ready_mode = 2;
    clear_rx();
    rd_count = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      smp.push_back(w);
      push_word(w);
    end
    start_frame();
    fired = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!fired && rd_count == 64 && m_valid && !m_last && m_ready) begin
        flush = 1'b1;
        fired = 1'b1;
      end
      tick();
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok || !fired) begin
      bad++;
      $display("FAIL full_flush_run: idle=%b flushed=%b want 1 1", ok, fired);
    end
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL full_flush_len: got %0d words want %0d", rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL full_flush_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
    // The next frame must not be closed by the flush that arrived with the
    // 64th sample.
    ready_mode = 0;
    clear_rx();
    smp = '{32'h0000_0010, 32'h0000_0020};
    foreach (smp[i]) push_word(smp[i]);
    start_frame();
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (busy !== 1'b1 || rx_q.size() != 3) begin
      bad++;
      $display("FAIL stale_flush: busy=%b words=%0d want 1 3", busy, rx_q.size());
    end
    flush = 1'b1;
    tick();
    wait_idle(100, ok);
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (!ok || rx_q.size() != fr.size() || rx_q[rx_q.size()-1] !== fr[fr.size()-1]) begin
      bad++;
      $display("FAIL stale_flush_frame: idle=%b words=%0d want %0d", ok, rx_q.size(), fr.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] smp[$], fr[$], w;
    bit ok;
    ready_mode = 1;
    clear_rx();
    rd_count  = 0;
    stall_err = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      smp.push_back(w);
      push_word(w);
    end
    start_frame();
    wait_idle(2000, ok);
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (!ok || rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL bp_len: idle=%b got %0d words want %0d", ok, rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL bp_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
    total++;
    if (stall_err != 0 || rd_count != 64) begin
      bad++;
      $display("FAIL bp_stall: unstable=%0d reads=%0d want 0 64", stall_err, rd_count);
    end
    ready_mode = 0;
  endtask

  task automatic test_underrun();
    logic [31:0] smp[$], fr[$], w;
    int reads_before;
    bit ok;
    ready_mode = 0;
    clear_rx();
    rd_count = 0;
    rd_viol  = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      smp.push_back(w);
      push_word(w);
    end
    start_frame();
    wait_pops(20, 200, ok);
    force_empty = 1'b1;
    fifo_sync();
    reads_before = rd_count;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (rd_count != reads_before || busy !== 1'b1) begin
      bad++;
      $display("FAIL underrun_hold: reads=%0d busy=%b want %0d 1", rd_count, busy, reads_before);
    end
    force_empty = 1'b0;
    fifo_sync();
    wait_idle(1000, ok);
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (!ok || rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL underrun_len: idle=%b got %0d words want %0d", ok, rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL underrun_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
    total++;
    if (rd_viol != 0) begin
      bad++;
      $display("FAIL rd_while_empty: got %0d strobes want 0", rd_viol);
    end
  endtask

  task automatic test_idle_disabled();
    ready_mode = 0;
    rd_count   = 0;
    enable     = 1'b0;
    for (int i = 0; i < 5; i++) push_word($urandom);
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || rd_count != 0) begin
      bad++;
      $display("FAIL idle_disabled: busy=%b valid=%b reads=%0d want 0 0 0", busy, m_valid, rd_count);
    end
    fifo_q.delete();
    fifo_sync();
  endtask

  task automatic test_seq_wrap();
    logic [31:0] smp[$], fr[$];
    bit ok;
    ready_mode = 0;
    force dut.seq = 16'hFFFF;
    tick();
    release dut.seq;
    tick();
    total++;
    if (seq !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: got %h want ffff", seq);
    end
    exp_seq = 16'hFFFF;
    for (int f = 0; f < 2; f++) begin
      clear_rx();
      smp = {};
      smp.push_back($urandom);
      push_word(smp[0]);
      start_frame();
      flush = 1'b1;
      tick();
      wait_idle(100, ok);
      build_frame(exp_seq, smp, fr);
      exp_seq++;
      total++;
      if (!ok || rx_q.size() != fr.size()) begin
        bad++;
        $display("FAIL wrap_len[%0d]: idle=%b got %0d words want %0d", f, ok, rx_q.size(), fr.size());
      end
      foreach (fr[i]) if (i < rx_q.size()) begin
        total++;
        if (rx_q[i] !== fr[i]) begin
          bad++;
          $display("FAIL wrap_word[%0d][%0d]: got %h want %h", f, i, rx_q[i], fr[i]);
        end
      end
      total++;
      if (seq !== exp_seq) begin
        bad++;
        $display("FAIL wrap_seq[%0d]: got %h want %h", f, seq, exp_seq);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] smp[$], fr[$], w;
    bit ok;
    ready_mode = 0;
    clear_rx();
    rd_count = 0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      push_word(w);
    end
    start_frame();
    wait_pops(5, 100, ok);   // now presenting the 5th sample
    rst = 1'b0;
    tick();
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || fifo_rd_en !== 1'b0 || m_data !== 32'h0) begin
      bad++;
      $display("FAIL midreset_out: valid=%b last=%b rd_en=%b data=%h want 0", m_valid, m_last, fifo_rd_en, m_data);
    end
    total++;
    if (busy !== 1'b0 || seq !== 16'h0) begin
      bad++;
      $display("FAIL midreset_seq: busy=%b seq=%h want 0 0000", busy, seq);
    end
    rst = 1'b1;
    exp_seq = 16'h0;
    smp = fifo_q;            // the FIFO keeps the words not yet read
    clear_rx();
    rd_count = 0;
    start_frame();
    wait_pops(smp.size(), 1000, ok);
    flush = 1'b1;
    tick();
    wait_idle(200, ok);
    build_frame(exp_seq, smp, fr);
    exp_seq++;
    total++;
    if (!ok || rx_q.size() != fr.size()) begin
      bad++;
      $display("FAIL midreset_len: idle=%b got %0d words want %0d", ok, rx_q.size(), fr.size());
    end
    foreach (fr[i]) if (i < rx_q.size()) begin
      total++;
      if (rx_q[i] !== fr[i] || rx_last[i] !== (i == fr.size() - 1)) begin
        bad++;
        $display("FAIL midreset_word[%0d]: got %h last=%b want %h", i, rx_q[i], rx_last[i], fr[i]);
      end
    end
  endtask

  // -------------------------------------------------------------------------
  initial begin
    rst     = 1'b0;
    enable  = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    fifo_sync();
    test_reset();
    test_full_frame();
    test_flush();
    test_flush_idle();
    test_flush_at_full();
    test_backpressure();
    test_underrun();
    test_idle_disabled();
    test_seq_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
